// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/MEM) and SRAM port bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              busy;
    logic              grant_mem;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  sram_rdata,
        output if_rdata, if_ready,
        output mem_rdata, mem_ready,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output busy, grant_mem
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output sram_rdata,
        input  if_rdata, if_ready,
        input  mem_rdata, mem_ready,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  busy, grant_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between IF fetch and MEM load/store.
// MEM_PORT_ARB_RR_EN selects round-robin contention; default is MEM priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sram_en_q, sram_en_d;
    logic              sram_we_q, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              grant_mem_q, grant_mem_d;

    logic any_req;
    logic prio_mem;
    logic win_mem;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // Contention goes to whoever did not win last time.
    assign prio_mem = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && any_req) begin
            last_grant_d = win_mem;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // MEM holds the older instruction, so it wins every tie.
    assign prio_mem = 1'b1;
`endif

    assign any_req = bus.if_req | bus.mem_req;
    assign win_mem = bus.mem_req & (~bus.if_req | prio_mem);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sram_en_d    = sram_en_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        grant_mem_d  = grant_mem_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_LOAD;
                    sram_en_d    = 1'b1;
                    grant_mem_d  = win_mem;
                    sram_we_d    = win_mem & bus.mem_we;
                    sram_addr_d  = win_mem ? bus.mem_addr : bus.if_addr;
                    sram_wdata_d = win_mem ? bus.mem_wdata : '0;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Only the granted side's read register ever moves.
                    if (!grant_mem_q) begin
                        if_rdata_d = bus.sram_rdata;
                    end else if (!sram_we_q) begin
                        mem_rdata_d = bus.sram_rdata;
                    end
                    sram_en_d   = 1'b0;
                    sram_we_d   = 1'b0;
                    if_ready_d  = ~grant_mem_q;
                    mem_ready_d = grant_mem_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            grant_mem_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            grant_mem_q  <= grant_mem_d;
        end
    end

    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.grant_mem  = grant_mem_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// random IF/MEM traffic against a cycle-count reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 2;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sram_a  [1024];
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // SRAM model: store commits on clock edges while enabled.
    initial begin
        for (int i = 0; i < 1024; i++) sram_a[i] = pat(32'(i) << 2);
        sram_a[4] = 32'hE3A00001;
        forever begin
            @(posedge clk);
            if (bus.sram_en === 1'b1 && bus.sram_we === 1'b1)
                sram_a[bus.sram_addr[11:2]] = bus.sram_wdata;
        end
    end

    always @(negedge clk) begin
        bus.sram_rdata  = sram_a[bus.sram_addr[11:2]];
        bus1.sram_rdata = sram_a[bus1.sram_addr[11:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus1.if_req    = 1'b0;
        bus1.if_addr   = '0;
        bus1.mem_req   = 1'b0;
        bus1.mem_we    = 1'b0;
        bus1.mem_addr  = '0;
        bus1.mem_wdata = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [133:0] outs;
        rst           = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h48;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h44;
        bus.mem_wdata = 32'h1234;
        step();
        step();
        outs = {bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata,
                bus.if_rdata, bus.mem_rdata, bus.if_ready, bus.mem_ready,
                bus.busy, bus.grant_mem};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        outs = {bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_wdata,
                bus1.if_rdata, bus1.mem_rdata, bus1.if_ready, bus1.mem_ready,
                bus1.busy, bus1.grant_mem};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outs_w1 got %h want 0", outs);
        end
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.if_addr = 32'h10;
        rst         = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (bus.sram_en !== (k <= 2)) begin
                n_bad++;
                $display("FAIL reset_fetch sram_en cyc %0d got %b", k, bus.sram_en);
            end
            n_cmp++;
            if (bus.if_ready !== (k == 3)) begin
                n_bad++;
                $display("FAIL reset_fetch if_ready cyc %0d got %b", k, bus.if_ready);
            end
            n_cmp++;
            if (bus.mem_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_fetch mem_ready cyc %0d got %b want 0", k, bus.mem_ready);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.if_rdata !== 32'hE3A00001) begin
                    n_bad++;
                    $display("FAIL reset_fetch if_rdata got %h want e3a00001", bus.if_rdata);
                end
            end
            if (k == 4) bus.if_req = 1'b0;
        end
    endtask

    task automatic test_store();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h400;
        bus.mem_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 2) begin
                n_cmp++;
                if ({bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}
                    !== {1'b1, 1'b1, 32'h400, 32'hDEADBEEF}) begin
                    n_bad++;
                    $display("FAIL store_bus cyc %0d got en=%b we=%b a=%h d=%h", k,
                             bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
                end
            end
            n_cmp++;
            if (bus.mem_ready !== (k == 3)) begin
                n_bad++;
                $display("FAIL store mem_ready cyc %0d got %b", k, bus.mem_ready);
            end
            n_cmp++;
            if (bus.if_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL store if_ready cyc %0d got %b want 0", k, bus.if_ready);
            end
            n_cmp++;
            if (bus.grant_mem !== 1'b1) begin
                n_bad++;
                $display("FAIL store grant_mem cyc %0d got %b want 1", k, bus.grant_mem);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.mem_rdata !== 32'h0 || bus.if_rdata !== 32'hE3A00001) begin
                    n_bad++;
                    $display("FAIL store rdata got m=%h i=%h want 0/e3a00001",
                             bus.mem_rdata, bus.if_rdata);
                end
            end
            if (k == 4) bus.mem_we = 1'b0;
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (bus.mem_ready !== (k == 3)) begin
                n_bad++;
                $display("FAIL loadback mem_ready cyc %0d got %b", k, bus.mem_ready);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.mem_rdata !== 32'hDEADBEEF) begin
                    n_bad++;
                    $display("FAIL loadback mem_rdata got %h want deadbeef", bus.mem_rdata);
                end
            end
            if (k == 4) bus.mem_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        pulse_reset();
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h20;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h24;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (bus.mem_ready !== (k == 3)) begin
                n_bad++;
                $display("FAIL contend mem_ready cyc %0d got %b", k, bus.mem_ready);
            end
            n_cmp++;
            if (bus.if_ready !== (k == 7)) begin
                n_bad++;
                $display("FAIL contend if_ready cyc %0d got %b", k, bus.if_ready);
            end
            n_cmp++;
            if (bus.grant_mem !== (k <= 4)) begin
                n_bad++;
                $display("FAIL contend grant_mem cyc %0d got %b", k, bus.grant_mem);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.mem_rdata !== pat(32'h20)) begin
                    n_bad++;
                    $display("FAIL contend mem_rdata got %h want %h", bus.mem_rdata, pat(32'h20));
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (bus.if_rdata !== pat(32'h24)) begin
                    n_bad++;
                    $display("FAIL contend if_rdata got %h want %h", bus.if_rdata, pat(32'h24));
                end
            end
            if (k == 4) bus.mem_req = 1'b0;
            if (k == 8) bus.if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h84;
        step();
        n_cmp++;
        if (bus.sram_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid pre sram_en got %b want 1", bus.sram_en);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.sram_en, bus.busy, bus.grant_mem} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid async en/busy/grant got %b%b%b want 000",
                     bus.sram_en, bus.busy, bus.grant_mem);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (bus.mem_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid ready during reset got %b", bus.mem_ready);
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (bus.mem_ready !== (k == W + 1)) begin
                n_bad++;
                $display("FAIL rstmid reissue mem_ready cyc %0d got %b", k, bus.mem_ready);
            end
            if (k == W + 1) begin
                n_cmp++;
                if (bus.mem_rdata !== pat(32'h84)) begin
                    n_bad++;
                    $display("FAIL rstmid mem_rdata got %h want %h", bus.mem_rdata, pat(32'h84));
                end
            end
            if (k == 4) bus.mem_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h80;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (bus1.if_ready !== (k % 3 == 2)) begin
                n_bad++;
                $display("FAIL b2b if_ready cyc %0d got %b", k, bus1.if_ready);
            end
            n_cmp++;
            if (bus1.busy !== (k % 3 != 0)) begin
                n_bad++;
                $display("FAIL b2b busy cyc %0d got %b", k, bus1.busy);
            end
            if (k % 3 == 2) begin
                exp = pat(32'h80 + 32'(4 * ((k - 2) / 3)));
                n_cmp++;
                if (bus1.if_rdata !== exp) begin
                    n_bad++;
                    $display("FAIL b2b if_rdata cyc %0d got %h want %h", k, bus1.if_rdata, exp);
                end
            end
            if (k % 3 == 0) bus1.if_addr = bus1.if_addr + 32'd4;
        end
        bus1.if_req = 1'b0;
    endtask

    task automatic test_random(input int ncyc, input int pct);
        bit          pend [2];
        bit          gnt  [2];
        bit          wev  [2];
        logic [31:0] adr  [2];
        logic [31:0] wdt  [2];
        logic [31:0] erd  [2];
        int          rdy_at [2];
        int          next_idle = 0;
        int          acc_c = -100;
        int          wn = 0;
        bit          last_mem = 1'b0;
        logic [31:0] exp_ird = '0;
        logic [31:0] exp_mrd = '0;
        bit          e_busy, e_en;
        pulse_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p]   = 1'b0;
            gnt[p]    = 1'b0;
            wev[p]    = 1'b0;
            adr[p]    = '0;
            wdt[p]    = '0;
            erd[p]    = '0;
            rdy_at[p] = -100;
        end
        for (int c = 0; c < ncyc; c++) begin
            e_busy = (c > acc_c) && (c <= acc_c + W + 1);
            e_en   = (c > acc_c) && (c <= acc_c + W);
            n_cmp++;
            if ({bus.if_ready, bus.mem_ready} !== {rdy_at[0] == c, rdy_at[1] == c}) begin
                n_bad++;
                $display("FAIL rnd ready c=%0d got %b%b want %b%b", c, bus.if_ready,
                         bus.mem_ready, rdy_at[0] == c, rdy_at[1] == c);
            end
            n_cmp++;
            if ({bus.busy, bus.sram_en} !== {e_busy, e_en}) begin
                n_bad++;
                $display("FAIL rnd busy/en c=%0d got %b%b want %b%b", c,
                         bus.busy, bus.sram_en, e_busy, e_en);
            end
            if (c == acc_c + 1) begin
                n_cmp++;
                if (bus.sram_addr !== adr[wn] || bus.sram_we !== (wn == 1 && wev[1])) begin
                    n_bad++;
                    $display("FAIL rnd sram c=%0d got a=%h we=%b want a=%h", c,
                             bus.sram_addr, bus.sram_we, adr[wn]);
                end
                if (wn == 1 && wev[1]) begin
                    n_cmp++;
                    if (bus.sram_wdata !== wdt[1]) begin
                        n_bad++;
                        $display("FAIL rnd sram_wdata c=%0d got %h want %h", c,
                                 bus.sram_wdata, wdt[1]);
                    end
                end
            end
            if (rdy_at[0] == c) exp_ird = erd[0];
            if (rdy_at[1] == c && !wev[1]) exp_mrd = erd[1];
            if (rdy_at[0] == c || rdy_at[1] == c) begin
                n_cmp++;
                if ({bus.if_rdata, bus.mem_rdata} !== {exp_ird, exp_mrd}) begin
                    n_bad++;
                    $display("FAIL rnd rdata c=%0d got i=%h m=%h want i=%h m=%h", c,
                             bus.if_rdata, bus.mem_rdata, exp_ird, exp_mrd);
                end
                n_cmp++;
                if (bus.grant_mem !== (wn == 1)) begin
                    n_bad++;
                    $display("FAIL rnd grant_mem c=%0d got %b want %b", c,
                             bus.grant_mem, wn == 1);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (gnt[p] && rdy_at[p] == c - 1) begin
                    pend[p] = 1'b0;
                    gnt[p]  = 1'b0;
                end
                if (!pend[p] && $urandom_range(99) < pct) begin
                    pend[p] = 1'b1;
                    adr[p]  = 32'($urandom_range(63)) << 2;
                    wev[p]  = (p == 1) ? 1'($urandom_range(1)) : 1'b0;
                    wdt[p]  = $urandom;
                end
            end
            bus.if_req    = pend[0];
            bus.if_addr   = pend[0] ? adr[0] : $urandom;
            bus.mem_req   = pend[1];
            bus.mem_addr  = pend[1] ? adr[1] : $urandom;
            bus.mem_we    = pend[1] ? wev[1] : 1'($urandom_range(1));
            bus.mem_wdata = pend[1] ? wdt[1] : $urandom;
            if (c >= next_idle && (pend[0] || pend[1])) begin
`ifdef MEM_PORT_ARB_RR_EN
                wn = (pend[1] && (!pend[0] || !last_mem)) ? 1 : 0;
`else
                wn = pend[1] ? 1 : 0;
`endif
                last_mem   = (wn == 1);
                gnt[wn]    = 1'b1;
                rdy_at[wn] = c + W + 1;
                next_idle  = c + W + 2;
                acc_c      = c;
                if (wn == 1 && wev[1])
                    ref_mem[adr[1][11:2]] = wdt[1];
                else
                    erd[wn] = ref_mem[adr[wn][11:2]];
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(32'(i) << 2);
        ref_mem[4] = 32'hE3A00001;
        idle_inputs();
        test_reset();
        test_store();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random(300, 40);
        test_random(80, 100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
